// File: rtl/scalar_wb_arbiter.sv
// Purpose : writeback collector for the scalar FUs. Buffers one completed result per FU,
//           grants one per cycle by round-robin, and registers the writeback bundle
//           (register write plus the FU-done tag that issue uses to free FUST rows).
//           Speculative results are dropped on a branch miss.
// Latency : handshake edge N -> wb_valid after edge N+1 (uncontended, no freeze).
//           With WB_BYPASS_EN defined, an empty slot's live source can win directly, so
//           wb_valid rises after the same edge as the handshake.
// Backpressure: src_ready[i] = slot empty, or slot granted this cycle with freeze low.
//           freeze stops all grants; once every slot is full, every src_ready is 0.
// Ports   : CLK/RST (async, active-high); src_valid/src_ready/src_rd/src_data/src_wen/
//           src_spec per source (packed, source i at slice i); branch_miss, branch_resolved,
//           freeze controls; wb_valid/wb_wen/wb_rd/wb_data/wb_fu registered writeback.
// Config  : `define WB_BYPASS_EN to let an empty slot's incoming result arbitrate directly.
module scalar_wb_arbiter #(
  parameter int NSRC   = 4,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int FU_W   = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NSRC-1:0]          src_valid,
  output logic [NSRC-1:0]          src_ready,
  input  logic [NSRC*REG_W-1:0]    src_rd,
  input  logic [NSRC*WORD_W-1:0]   src_data,
  input  logic [NSRC-1:0]          src_wen,
  input  logic [NSRC-1:0]          src_spec,
  input  logic                     branch_miss,
  input  logic                     branch_resolved,
  input  logic                     freeze,
  output logic                     wb_valid,
  output logic                     wb_wen,
  output logic [REG_W-1:0]         wb_rd,
  output logic [WORD_W-1:0]        wb_data,
  output logic [FU_W-1:0]          wb_fu
);

  // Slot storage: one entry per source.
  logic [NSRC-1:0]   slot_v_q,    slot_v_d;
  logic [NSRC-1:0]   slot_spec_q, slot_spec_d;
  logic [NSRC-1:0]   slot_wen_q,  slot_wen_d;
  logic [REG_W-1:0]  slot_rd_q   [NSRC];
  logic [REG_W-1:0]  slot_rd_d   [NSRC];
  logic [WORD_W-1:0] slot_data_q [NSRC];
  logic [WORD_W-1:0] slot_data_d [NSRC];

  logic [FU_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Registered writeback bundle.
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wen_q,   wb_wen_d;
  logic [REG_W-1:0]  wb_rd_q,    wb_rd_d;
  logic [WORD_W-1:0] wb_data_q,  wb_data_d;
  logic [FU_W-1:0]   wb_fu_q,    wb_fu_d;

  // Unpacked views of the incoming per-source fields.
  logic [REG_W-1:0]  in_rd   [NSRC];
  logic [WORD_W-1:0] in_data [NSRC];

  logic [NSRC-1:0]   cand;
  logic [NSRC-1:0]   grant;
  logic              grant_any;
  logic [FU_W-1:0]   win_idx;
  logic [REG_W-1:0]  win_rd;
  logic [WORD_W-1:0] win_data;
  logic              win_wen;
  logic [NSRC-1:0]   hs;
  logic [NSRC-1:0]   byp_take;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      in_rd[i]   = src_rd[i*REG_W +: REG_W];
      in_data[i] = src_data[i*WORD_W +: WORD_W];
    end
  end

  // Candidates. A speculative slot is masked while branch_miss is high so it can never
  // win in the same cycle it is being flushed.
  always_comb begin
    cand = slot_v_q & ~({NSRC{branch_miss}} & slot_spec_q);
`ifdef WB_BYPASS_EN
    cand = cand | (~slot_v_q & src_valid & ~({NSRC{branch_miss}} & src_spec));
`endif
  end

  // Round-robin scan starting at rr_ptr. Uses only slot state (plus bypass sources of
  // empty slots), so a source's own src_valid never feeds back into its src_ready.
  always_comb begin
    int              j;
    logic [FU_W-1:0] idx;
    j         = 0;
    idx       = '0;
    grant     = '0;
    grant_any = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NSRC) j = j - NSRC;
      idx = FU_W'(j);
      if (!grant_any && !freeze && cand[idx]) begin
        grant_any = 1'b1;
        win_idx   = idx;
      end
    end
    if (grant_any) grant[win_idx] = 1'b1;
  end

  // Winner fields: the buffered entry, or the live source when bypassing an empty slot.
  always_comb begin
    win_rd   = slot_rd_q[win_idx];
    win_data = slot_data_q[win_idx];
    win_wen  = slot_wen_q[win_idx];
`ifdef WB_BYPASS_EN
    if (!slot_v_q[win_idx]) begin
      win_rd   = in_rd[win_idx];
      win_data = in_data[win_idx];
      win_wen  = src_wen[win_idx];
    end
`endif
  end

  assign src_ready = ~slot_v_q | (grant & {NSRC{~freeze}});
  assign hs        = src_valid & src_ready;

`ifdef WB_BYPASS_EN
  // A granted empty slot means the live result went straight to writeback.
  assign byp_take = grant & ~slot_v_q;
`else
  assign byp_take = '0;
`endif

  // Slot next state. Order matters: drain, then miss/resolve on the held entry, then
  // the incoming handshake. A miss takes priority over a same-cycle resolve, so a
  // speculative entry is killed rather than promoted.
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_spec_d = slot_spec_q;
    slot_wen_d  = slot_wen_q;
    for (int i = 0; i < NSRC; i++) begin
      slot_rd_d[i]   = slot_rd_q[i];
      slot_data_d[i] = slot_data_q[i];
    end
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i] && slot_v_q[i]) slot_v_d[i] = 1'b0;
      if (branch_miss && slot_spec_q[i]) begin
        slot_v_d[i] = 1'b0;
      end else if (branch_resolved) begin
        slot_spec_d[i] = 1'b0;
      end
      // A speculative result arriving during a miss is accepted and thrown away.
      if (hs[i] && !byp_take[i] && !(branch_miss && src_spec[i])) begin
        slot_v_d[i]    = 1'b1;
        slot_spec_d[i] = src_spec[i] & ~branch_resolved;
        slot_wen_d[i]  = src_wen[i];
        slot_rd_d[i]   = in_rd[i];
        slot_data_d[i] = in_data[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = grant_any;
    // rd 0 is the hardwired zero register: never report a write to it.
    wb_wen_d   = grant_any & win_wen & (win_rd != '0);
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_fu_d    = wb_fu_q;
    if (grant_any) begin
      rr_ptr_d  = (win_idx == FU_W'(NSRC-1)) ? '0 : win_idx + 1'b1;
      wb_rd_d   = win_rd;
      wb_data_d = win_data;
      wb_fu_d   = win_idx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_v_q    <= '0;
      slot_spec_q <= '0;
      slot_wen_q  <= '0;
      for (int i = 0; i < NSRC; i++) begin
        slot_rd_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_fu_q    <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_spec_q <= slot_spec_d;
      slot_wen_q  <= slot_wen_d;
      for (int i = 0; i < NSRC; i++) begin
        slot_rd_q[i]   <= slot_rd_d[i];
        slot_data_q[i] <= slot_data_d[i];
      end
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_fu_q    <= wb_fu_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_wen   = wb_wen_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_fu    = wb_fu_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
module tb_scalar_wb_arbiter;
  localparam int NSRC   = 4;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int FU_W   = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic [NSRC-1:0]        src_valid = '0;
  logic [NSRC-1:0]        src_ready;
  logic [NSRC*REG_W-1:0]  src_rd = '0;
  logic [NSRC*WORD_W-1:0] src_data = '0;
  logic [NSRC-1:0]        src_wen = '0;
  logic [NSRC-1:0]        src_spec = '0;
  logic                   branch_miss = 1'b0;
  logic                   branch_resolved = 1'b0;
  logic                   freeze = 1'b0;
  logic                   wb_valid;
  logic                   wb_wen;
  logic [REG_W-1:0]       wb_rd;
  logic [WORD_W-1:0]      wb_data;
  logic [FU_W-1:0]        wb_fu;

  scalar_wb_arbiter #(.NSRC(NSRC), .WORD_W(WORD_W), .REG_W(REG_W), .FU_W(FU_W)) dut (
    .CLK(CLK), .RST(RST),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd), .src_data(src_data),
    .src_wen(src_wen), .src_spec(src_spec),
    .branch_miss(branch_miss), .branch_resolved(branch_resolved), .freeze(freeze),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fu(wb_fu)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic              wen;
    logic [REG_W-1:0]  rd;
    logic [WORD_W-1:0] data;
    logic [FU_W-1:0]   fu;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_got;
  wb_t mon_exp;
  int  n_checks = 0;
  int  n_fail   = 0;
  logic [NSRC-1:0] hs;
  int  cnt [NSRC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic wb_t mk(input logic [FU_W-1:0] fu, input logic [REG_W-1:0] rd,
                             input logic [WORD_W-1:0] data, input logic wen);
    return wb_t'({wen, rd, data, fu});
  endfunction

  // Monitor: every writeback pulse must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST) begin
      if (wb_valid) begin
        mon_got = wb_t'({wb_wen, wb_rd, wb_data, wb_fu});
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wb: got %0h expected nothing", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wb_bundle", 64'(mon_got), 64'(mon_exp));
        end
      end else begin
        check("wen_when_idle", 64'(wb_wen), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int i, input logic [REG_W-1:0] rd, input logic [WORD_W-1:0] d,
                       input logic wen, input logic spec);
    src_valid[i]               = 1'b1;
    src_rd[i*REG_W +: REG_W]   = rd;
    src_data[i*WORD_W +: WORD_W] = d;
    src_wen[i]                 = wen;
    src_spec[i]                = spec;
  endtask

  task automatic idle_all();
    src_valid = '0;
    src_spec  = '0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_src_ready", 64'(src_ready), 64'hf);
    RST = 1'b0;
    check("rst_wb_fu_rd_data", {wb_fu, wb_rd, wb_data}, 64'(0));

    // Contention: all four held valid, two results each -> fu 0,1,2,3,0,1,2,3
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NSRC; s++)
        exp_q.push_back(mk(FU_W'(s), REG_W'(1 + s + 4*r), 32'hA000_0000 | 32'(s << 8) | 32'(r), 1'b1));
    for (int s = 0; s < NSRC; s++) cnt[s] = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (cnt[s] < 2)
          drive(s, REG_W'(1 + s + 4*cnt[s]), 32'hA000_0000 | 32'(s << 8) | 32'(cnt[s]), 1'b1, 1'b0);
        else
          src_valid[s] = 1'b0;
      end
      @(negedge CLK);
      hs = src_valid & src_ready;
      tick();
      for (int s = 0; s < NSRC; s++) if (hs[s]) cnt[s]++;
    end
    idle_all();
    check("contention_accepted", {32'(cnt[0] + cnt[1]), 32'(cnt[2] + cnt[3])}, {32'd4, 32'd4});
    wait_drain("contention_drain");

    // Single ALU result, latency check (rr_ptr = 0 here)
    drive(0, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    exp_q.push_back(mk(2'd0, 5'd5, 32'hDEAD_BEEF, 1'b1));
    check("single_ready", 64'(src_ready[0]), 64'(1));
    tick();
    idle_all();
    check("lat_after_hs_edge", 64'(wb_valid), 64'(BYP));
    tick();
    check("lat_one_edge_later", 64'(wb_valid), 64'(!BYP));
    wait_drain("single_drain");

    // rd=0 write suppressed; store (wen=0) still reports done
    drive(0, 5'd0, 32'h0000_0011, 1'b1, 1'b0);
    exp_q.push_back(mk(2'd0, 5'd0, 32'h0000_0011, 1'b0));
    tick();
    idle_all();
    wait_drain("rd0_drain");
    drive(2, 5'd7, 32'h0000_0022, 1'b0, 1'b0);
    exp_q.push_back(mk(2'd2, 5'd7, 32'h0000_0022, 1'b0));
    tick();
    idle_all();
    wait_drain("store_drain");

    // Flush: ALU non-spec + LDST spec buffered, miss pulse; a spec result from BRANCH
    // arriving during the miss is discarded too.
    drive(0, 5'd9, 32'h0000_0033, 1'b1, 1'b0);
    drive(1, 5'd10, 32'h0000_0044, 1'b1, 1'b1);
    exp_q.push_back(mk(2'd0, 5'd9, 32'h0000_0033, 1'b1));
    tick();
    idle_all();
    branch_miss = 1'b1;
    drive(2, 5'd11, 32'h0000_0055, 1'b1, 1'b1);
    check("miss_spec_in_ready", 64'(src_ready[2]), 64'(1));
    tick();
    branch_miss = 1'b0;
    idle_all();
    tick();
    check("flush_slots_empty", 64'(src_ready), 64'hf);
    wait_drain("flush_drain");
    repeat (3) tick();

    // Resolve promotes a spec entry, so a later miss leaves it alone
    freeze = 1'b1;
    drive(1, 5'd12, 32'h0000_0066, 1'b1, 1'b1);
    tick();
    idle_all();
    branch_resolved = 1'b1;
    tick();
    branch_resolved = 1'b0;
    branch_miss = 1'b1;
    tick();
    branch_miss = 1'b0;
    check("resolved_kept", 64'(src_ready[1]), 64'(0));
    exp_q.push_back(mk(2'd1, 5'd12, 32'h0000_0066, 1'b1));
    freeze = 1'b0;
    wait_drain("resolve_drain");

    // Miss and resolve together: the miss wins
    freeze = 1'b1;
    drive(3, 5'd13, 32'h0000_0077, 1'b1, 1'b1);
    tick();
    idle_all();
    branch_miss = 1'b1;
    branch_resolved = 1'b1;
    tick();
    branch_miss = 1'b0;
    branch_resolved = 1'b0;
    check("miss_beats_resolve", 64'(src_ready[3]), 64'(1));
    freeze = 1'b0;
    repeat (3) tick();

    // Freeze with all slots full (rr_ptr = 2) -> drain order 2,3,0,1 on release
    freeze = 1'b1;
    for (int s = 0; s < NSRC; s++) drive(s, REG_W'(16 + s), 32'h0000_00F0 + 32'(s), 1'b1, 1'b0);
    tick();
    idle_all();
    for (int k = 0; k < 3; k++) begin
      check("freeze_ready", 64'(src_ready), 64'(0));
      check("freeze_wb_valid", 64'(wb_valid), 64'(0));
      tick();
    end
    exp_q.push_back(mk(2'd2, 5'd18, 32'h0000_00F2, 1'b1));
    exp_q.push_back(mk(2'd3, 5'd19, 32'h0000_00F3, 1'b1));
    exp_q.push_back(mk(2'd0, 5'd16, 32'h0000_00F0, 1'b1));
    exp_q.push_back(mk(2'd1, 5'd17, 32'h0000_00F1, 1'b1));
    freeze = 1'b0;
    wait_drain("freeze_drain");

    // Reset mid-burst: one result out (fu2), then reset drops the other three
    freeze = 1'b1;
    for (int s = 0; s < NSRC; s++) drive(s, REG_W'(20 + s), 32'h0000_00B0 + 32'(s), 1'b1, 1'b0);
    tick();
    idle_all();
    exp_q.push_back(mk(2'd2, 5'd22, 32'h0000_00B2, 1'b1));
    freeze = 1'b0;
    tick();
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("midrst_wb_valid", 64'(wb_valid), 64'(0));
    check("midrst_src_ready", 64'(src_ready), 64'hf);
    check("midrst_wb_fu", 64'(wb_fu), 64'(0));
    check("midrst_queue", 64'(exp_q.size()), 64'(0));
    tick();
    RST = 1'b0;
    repeat (2) tick();
    // rr_ptr back at 0: ALU beats MATRIX
    drive(3, 5'd3, 32'h0000_00C3, 1'b1, 1'b0);
    drive(0, 5'd1, 32'h0000_00C0, 1'b1, 1'b0);
    exp_q.push_back(mk(2'd0, 5'd1, 32'h0000_00C0, 1'b1));
    exp_q.push_back(mk(2'd3, 5'd3, 32'h0000_00C3, 1'b1));
    tick();
    idle_all();
    wait_drain("post_rst_drain");
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
